// File: rtl/mem_stage_wait_ctrl.sv
// Multi-cycle data-memory stage: word array behind a fixed wait-state sequence,
// stalls the pipeline while busy, flags bad addresses, counts frozen cycles.
module mem_stage_wait_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic                   freeze,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ready,
    output logic                   addr_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);
    // state | meaning
    // IDLE  | no access in flight; a request is accepted and latched
    // BUSY  | wait states running; access happens on the last one
    // DONE  | access complete, ready pulses, pipeline released

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 8;
    localparam logic [ADDR_W:0]   ADDR_LO  = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0]   ADDR_HI  = (ADDR_W+1)'(BASE_ADDR + 4 * DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              op_wr_q;
    logic              in_rng_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              req;
    logic              in_range;
    logic [IDX_W-1:0]  idx_in;
    logic              last;
    logic              access;

    assign req      = rd_en | wr_en;
    assign in_range = ({1'b0, addr} >= ADDR_LO) && ({1'b0, addr} < ADDR_HI);
    assign idx_in   = IDX_W'((addr - ADDR_W'(BASE_ADDR)) >> 2);
    assign last     = (wait_cnt == CNT_LAST);
    assign access   = (state == BUSY) && req && last;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = BUSY;
            BUSY: begin
                if (!req)
                    state_nxt = IDLE;
                else if (last)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        freeze = 1'b0;
        ready  = 1'b0;
        case (state)
            IDLE:    freeze = req;
            BUSY:    freeze = req;
            DONE:    ready  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt  <= '0;
            op_wr_q   <= 1'b0;
            in_rng_q  <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            rdata     <= '0;
            addr_err  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (state == IDLE && req) begin
                wait_cnt <= '0;
                op_wr_q  <= wr_en;
                in_rng_q <= in_range;
                idx_q    <= idx_in;
                wdata_q  <= wdata;
                if (!in_range || (rd_en && wr_en))
                    addr_err <= 1'b1;
            end else if (state == BUSY && req) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // Out-of-range loads return zero rather than aliasing into the array.
            if (access && !op_wr_q)
                rdata <= in_rng_q ? mem[idx_q] : '0;
            if (freeze && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Array is never reset, but a write is blocked on a reset edge.
    always_ff @(posedge clk) begin
        if (rst && access && op_wr_q && in_rng_q)
            mem[idx_q] <= wdata_q;
    end
endmodule

// File: tb/tb_mem_stage_wait_ctrl.sv
// Bench for mem_stage_wait_ctrl: directed accesses, scoreboard of expected
// {addr_err, rdata} popped by a monitor on every ready pulse.
module tb_mem_stage_wait_ctrl;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int WAITC  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_en, wr_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              freeze, ready, addr_err;
    logic [DATA_W-1:0] rdata;
    logic [15:0]       stall_cnt;

    logic              s_freeze, s_ready, s_addr_err;
    logic [DATA_W-1:0] s_rdata;
    logic [2:0]        s_stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_stall = 0;
    logic [DATA_W:0] sb [$];

    always #5 clk = ~clk;

    mem_stage_wait_ctrl #(.WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wdata(wdata), .freeze(freeze), .rdata(rdata), .ready(ready),
        .addr_err(addr_err), .stall_cnt(stall_cnt));

    mem_stage_wait_ctrl #(.WAIT_CYCLES(WAITC), .STALL_CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wdata(wdata), .freeze(s_freeze), .rdata(s_rdata), .ready(s_ready),
        .addr_err(s_addr_err), .stall_cnt(s_stall_cnt));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_stall(input string name);
        check({name, "_stall"}, 64'(stall_cnt), 64'(exp_stall));
        check({name, "_sat"}, 64'(s_stall_cnt), 64'((exp_stall > 7) ? 7 : exp_stall));
    endtask

    // Monitor: every ready pulse must match the next queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_ready: got ready=1 expected no pending access");
                end else begin
                    logic [DATA_W:0] e;
                    e = sb.pop_front();
                    check("mon_rdata", 64'(rdata), 64'(e[DATA_W-1:0]));
                    check("mon_addr_err", 64'(addr_err), 64'(e[DATA_W]));
                end
            end
        end
    end

    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             input logic [DATA_W-1:0] exp_rdata, input logic exp_err);
        int nfrz;
        int rdy_cyc;
        bit got;
        nfrz = 0;
        rdy_cyc = -1;
        got = 0;
        @(posedge clk); #1;
        sb.push_back({exp_err, exp_rdata});
        rd_en = rd; wr_en = wr; addr = a; wdata = d;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (c == 2) begin
                addr  = a ^ 32'h0000_0010;
                wdata = ~d;
            end
            if (freeze) nfrz++;
            if (ready) begin
                got = 1;
                rdy_cyc = c;
                rd_en = 1'b0; wr_en = 1'b0;
                check({name, "_freeze_at_ready"}, 64'(freeze), 64'd0);
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            n_chk++;
            $display("FAIL %s_timeout: got no ready expected ready within 40 cycles", name);
            rd_en = 1'b0; wr_en = 1'b0;
        end
        exp_stall += WAITC + 1;
        check({name, "_ready_cycle"}, 64'(rdy_cyc), 64'(WAITC + 1));
        check({name, "_freeze_cycles"}, 64'(nfrz), 64'(WAITC + 1));
        check_stall(name);
    endtask

    initial begin
        int nrdy;
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_freeze", 64'(freeze), 64'd0);
        check("rst_addr_err", 64'(addr_err), 64'd0);
        check_stall("rst");

        do_access("wr1024", 0, 1, 32'd1024, 32'hDEADBEEF, 32'h0, 0);
        do_access("rd1024", 1, 0, 32'd1024, 32'h0, 32'hDEADBEEF, 0);

        do_access("wr1028", 0, 1, 32'd1028, 32'h1, 32'hDEADBEEF, 0);
        do_access("rd1028", 1, 0, 32'd1028, 32'h0, 32'h1, 0);

        // Abort: write dropped in cycle 2 must leave the old value in place.
        do_access("wr1032", 0, 1, 32'd1032, 32'h1234, 32'h1, 0);
        @(posedge clk); #1;
        wr_en = 1'b1; addr = 32'd1032; wdata = 32'h55;
        @(negedge clk); check("abort_frz0", 64'(freeze), 64'd1);
        @(posedge clk); #1;
        @(negedge clk); check("abort_frz1", 64'(freeze), 64'd1);
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk); check("abort_frz2", 64'(freeze), 64'd0);
        exp_stall += 2;
        nrdy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ready) nrdy++;
        end
        check("abort_no_ready", 64'(nrdy), 64'd0);
        check_stall("abort");
        do_access("rd1032", 1, 0, 32'd1032, 32'h0, 32'h1234, 0);

        // Reset on the last wait state of a write: write must not land.
        do_access("wr1040", 0, 1, 32'd1040, 32'hAAAA, 32'h1234, 0);
        @(posedge clk); #1;
        wr_en = 1'b1; addr = 32'd1040; wdata = 32'hBBBB;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0;
        exp_stall = 0;
        @(negedge clk);
        check("midrst_rdata", 64'(rdata), 64'd0);
        check("midrst_ready", 64'(ready), 64'd0);
        check("midrst_freeze", 64'(freeze), 64'd0);
        check_stall("midrst");
        do_access("rd1040", 1, 0, 32'd1040, 32'h0, 32'hAAAA, 0);

        do_access("both1036", 1, 1, 32'd1036, 32'h77, 32'hAAAA, 1);
        do_access("rd1036", 1, 0, 32'd1036, 32'h0, 32'h77, 1);

        do_access("rd1020", 1, 0, 32'd1020, 32'h0, 32'h0, 1);
        do_access("rd1036b", 1, 0, 32'd1036, 32'h0, 32'h77, 1);
        do_access("wr1280", 0, 1, 32'd1280, 32'h9999, 32'h77, 1);
        repeat (5) @(negedge clk);
        check("err_sticky", 64'(addr_err), 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        exp_stall = 0;
        @(negedge clk);
        check("err_cleared", 64'(addr_err), 64'd0);
        check_stall("final_rst");

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_stage_wait_ctrl.md
Name: mem_stage_wait_ctrl

Overview:
- Parametrised, multi-cycle data-memory stage for the 5-stage ARM pipeline. Replaces the single-cycle data memory.
- Word array with a configurable number of wait states. Asserts freeze to stall the pipeline while an access is in flight.
- Flags out-of-range addresses and keeps a saturating stall-cycle counter for performance measurement.
- Sits between the EXE/MEM pipeline register and the MEM/WB pipeline register. freeze feeds the IF/ID/EXE/MEM register enables.

Parameters:
- DATA_W, 32, data word width in bits.
- ADDR_W, 32, byte-address width.
- DEPTH, 64, number of words in the array (power of two).
- BASE_ADDR, 1024, byte address of word 0.
- WAIT_CYCLES, 4, busy cycles per access; legal range 1..255.
- STALL_CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- rd_en  in  1  load request from the EXE/MEM register.
- wr_en  in  1  store request from the EXE/MEM register.
- addr  in  ADDR_W  byte address (ALU result).
- wdata  in  DATA_W  store data (Rm value).
- freeze  out  1  pipeline stall; combinational from state and request.
- rdata  out  DATA_W  registered load result.
- ready  out  1  one-cycle pulse on the access-complete cycle.
- addr_err  out  1  sticky error flag.
- stall_cnt  out  STALL_CNT_W  saturating count of frozen cycles.

Behaviour:
- Reset is sampled on the clk edge only, when rst==0. Reset values: state=IDLE, wait count=0, rdata=0, ready=0, addr_err=0, stall_cnt=0. The word array is not reset.
- req = rd_en | wr_en. Word index = (addr - BASE_ADDR) >> 2. Address bits [1:0] are ignored.
- In range means BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH.
- FSM states are IDLE, BUSY and DONE.
- IDLE:
  - If req, latch addr, wdata and op (write if wr_en), clear the wait count, go to BUSY.
  - freeze = req.
- BUSY:
  - freeze = 1 and the wait count increments each cycle.
  - On the cycle the count reaches WAIT_CYCLES-1, perform the access at the clock edge:
    - write: array[index] <= latched wdata;
    - read: rdata <= array[index].
  - Then go to DONE.
  - Changes to addr and wdata during BUSY are ignored.
- DONE:
  - freeze = 0 and ready = 1 for exactly this cycle, so the MEM/WB register captures rdata. Next state is IDLE.
  - A req seen in the following IDLE cycle is treated as the next instruction.
- Latency: a request first seen in cycle 0 completes in cycle WAIT_CYCLES+1.
  - freeze is high for WAIT_CYCLES+1 consecutive cycles (cycles 0..WAIT_CYCLES).
  - ready is high in cycle WAIT_CYCLES+1.
- Abort: if req drops to 0 while in BUSY (pipeline flush), return to IDLE next edge.
  - No write is performed, rdata is unchanged and ready is not pulsed.
  - freeze = 0 in the cycle req is 0.
- rd_en and wr_en both high at acceptance: treated as a write; addr_err is set.
- Out-of-range access:
  - Full wait sequence and ready pulse as normal.
  - A write is suppressed; a read loads rdata with 0.
  - addr_err is set.
- addr_err stays set until reset.
- rdata holds the last completed read value through writes and idle cycles.
- stall_cnt increments by 1 on every cycle where freeze==1 and saturates at all-ones.
- Reset asserted mid-BUSY: the access is abandoned (no write), all outputs take their reset values, and freeze=0 from the next cycle unless req is still high.

Test Plan:
- WAIT_CYCLES=4, write addr=1024 wdata=0xDEADBEEF, hold request -> freeze high for cycles 0..4, ready pulses in cycle 5, stall_cnt=5. Then read 1024 -> rdata=0xDEADBEEF in cycle 5 of the read; stall_cnt=10.
- Back-to-back: write 1028=0x1, then read 1028 starting the cycle after DONE -> two separate 5-cycle freezes with freeze=0 between them; rdata=0x1.
- Abort: start a write to 1032=0x55, drop wr_en in cycle 2 -> freeze=0 in cycle 2, no ready. A later read of 1032 returns the prior value, not 0x55.
- Out of range: read addr=1020 and write addr=1024+4*64 -> each completes with ready, read gives rdata=0, addr_err=1. addr_err stays 1 until rst=0.
- rd_en=wr_en=1 at 1036 with wdata=0x77 -> write performed (a later read gives 0x77), addr_err=1.
- Reset: assert rst=0 during BUSY of a write to 1040 -> next cycle rdata=0, ready=0, stall_cnt=0, no write. Repeat with STALL_CNT_W=3 to show stall_cnt saturating at 7.
